// File: rtl/pipe_defs.sv
// pipe_defs: shared ID/EX control-bundle bit positions and skid occupancy encodings.
package pipe_defs;
    localparam int CTRLW = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMTOREG = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUOP1   = 2;
    localparam int CTRL_ALUOP0   = 1;
    localparam int CTRL_ALUSRC   = 0;
    // Encoded as {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_ONE   = 2'b01,
        OCC_FULL  = 2'b11
    } occ_e;
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one valid bit plus a load-enabled payload register.
module pipe_skid_slot #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_d,
    input  logic          ld,
    input  logic [DW-1:0] d,
    output logic          vld,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= '0;
        end else begin
            vld <= vld_d;
            if (ld) q <= d;
        end
    end
endmodule

// File: rtl/latch_id_ex_skid.sv
// latch_id_ex_skid: ID->EX register as a 2-entry skid buffer with flush and bubble masking.
module latch_id_ex_skid #(
    parameter int B     = 32,
    parameter int W     = 5,
    parameter int PCW   = 32,
    parameter int CTRLW = pipe_defs::CTRLW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PCW-1:0]   pc_next_in,
    input  logic [B-1:0]     r_data1_in,
    input  logic [B-1:0]     r_data2_in,
    input  logic [B-1:0]     sign_ext_in,
    input  logic [W-1:0]     rt_in,
    input  logic [W-1:0]     rd_in,
    input  logic [CTRLW-1:0] ctrl_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PCW-1:0]   pc_next_out,
    output logic [B-1:0]     r_data1_out,
    output logic [B-1:0]     r_data2_out,
    output logic [B-1:0]     sign_ext_out,
    output logic [W-1:0]     rt_out,
    output logic [W-1:0]     rd_out,
    output logic [CTRLW-1:0] ctrl_out
);
    import pipe_defs::*;

    localparam int PW = PCW + 3*B + 2*W + CTRLW;

    logic          main_v, skid_v, main_vd, skid_vd, main_ld, skid_ld, main_sel_skid;
    logic [PW-1:0] in_pl, main_q, skid_q;
    logic [CTRLW-1:0] main_ctrl;
    logic          accept, pop;
    occ_e          occ;

    assign in_pl    = {pc_next_in, r_data1_in, r_data2_in, sign_ext_in, rt_in, rd_in, ctrl_in};
    assign occ      = occ_e'({skid_v, main_v});
    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = main_v & out_ready;

    always_comb begin
        main_vd       = main_v;
        skid_vd       = skid_v;
        main_ld       = 1'b0;
        skid_ld       = 1'b0;
        main_sel_skid = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                main_ld = accept;
                main_vd = accept;
            end
            OCC_ONE: begin
                main_ld = accept & pop;
                skid_ld = accept & ~pop;
                skid_vd = accept & ~pop;
                main_vd = accept | ~pop;
            end
            OCC_FULL: begin
                main_ld       = pop;
                main_sel_skid = pop;
                skid_vd       = ~pop;
            end
            default: begin
                main_vd = 1'b0;
                skid_vd = 1'b0;
            end
        endcase
        // Squash wins over everything; the discarded input never touches the payload flops.
        if (flush) begin
            main_vd = 1'b0;
            skid_vd = 1'b0;
            main_ld = 1'b0;
            skid_ld = 1'b0;
        end
    end

    pipe_skid_slot #(.DW(PW)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_d (main_vd),
        .ld    (main_ld),
        .d     (main_sel_skid ? skid_q : in_pl),
        .vld   (main_v),
        .q     (main_q)
    );

    pipe_skid_slot #(.DW(PW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_d (skid_vd),
        .ld    (skid_ld),
        .d     (in_pl),
        .vld   (skid_v),
        .q     (skid_q)
    );

    assign {pc_next_out, r_data1_out, r_data2_out, sign_ext_out, rt_out, rd_out, main_ctrl} = main_q;
    assign out_valid = main_v;
    assign ctrl_out  = main_v ? main_ctrl : '0;
endmodule
